// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// FSM states, load/store size codes and the IO window decode.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int         IO_HI  = 17;
    localparam int         IO_LO  = 16;
    localparam logic [1:0] IO_SEL = 2'b11;

    // The reserved size code 3 moves a full word, same as SZ_W.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto an 8-bit RAM port, assembling and splitting words inline.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              clear
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic              pend_q, pend_d;
    logic              is_ls_q, is_ls_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        cap_idx;
    logic [7:0]        wr_byte;
    logic              io_stall;

    // cnt_q counts issued bytes; a pending byte is always the one issued last cycle.
    assign cur_addr = addr_q + ADDR_W'(cnt_q);
    assign cap_idx  = 2'(cnt_q - 3'd1);
    assign wr_byte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    assign io_stall = io_buffer_full && (cur_addr[IO_HI:IO_LO] == IO_SEL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        pend_d     = pend_q;
        is_ls_d    = is_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        mem_a      = '0;
        mem_wr     = 1'b0;
        mem_dout   = '0;

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    if (ls_req && (!clear || ls_we)) begin
                        is_ls_d = 1'b1;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        n_d     = size_bytes(ls_size);
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                        state_d = ls_we ? WRITE : READ;
                        if (!ls_we) ls_rdata_d = '0;
                    end else if (if_req && !clear) begin
                        is_ls_d   = 1'b0;
                        addr_d    = if_addr;
                        n_d       = 3'd4;
                        cnt_d     = 3'd0;
                        pend_d    = 1'b0;
                        if_data_d = '0;
                        state_d   = READ;
                    end
                end
            end

            READ: begin
                mem_a = cur_addr;
                // A stall discards the byte in flight so it gets re-requested.
                if (!rdy) begin
                    if (pend_q) cnt_d = cnt_q - 3'd1;
                    pend_d = 1'b0;
                end else if (clear) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    pend_d  = 1'b0;
                end else begin
                    if (cnt_q < n_q) begin
                        cnt_d  = cnt_q + 3'd1;
                        pend_d = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                    if (pend_q) begin
                        if (is_ls_q) ls_rdata_d[{cap_idx, 3'b000} +: 8] = mem_din;
                        else         if_data_d[{cap_idx, 3'b000} +: 8]  = mem_din;
                        if (cnt_q == n_q) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            pend_d  = 1'b0;
                            if (is_ls_q) ls_done_d = 1'b1;
                            else         if_done_d = 1'b1;
                        end
                    end
                end
            end

            WRITE: begin
                mem_a    = cur_addr;
                mem_dout = wr_byte;
                mem_wr   = rdy && !io_stall;
                if (rdy && !io_stall) begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_d   = IDLE;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            pend_q     <= 1'b0;
            is_ls_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            is_ls_q    <= is_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, spec-level reference
// model, vector table, hand-written corner sequences and random traffic.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        clear;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram       [0:4095];
    logic [7:0]  model_mem [0:4095];
    bit          loaded = 1'b0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .clear(clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up RAM image, including the fetch program and the 0xFF load byte.
    function automatic logic [7:0] pattern(input logic [11:0] idx);
        case (idx)
            12'h100: return 8'h13;
            12'h101: return 8'h05;
            12'h102: return 8'h10;
            12'h103: return 8'h00;
            12'h200: return 8'hFF;
            default: return idx[7:0] ^ {idx[11:8], 4'h5};
        endcase
    endfunction

    // RAM model: 4 KiB aliased on the low address bits, read data one cycle late.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pattern(12'(i));
            loaded <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wr_cnt           <= wr_cnt + 1;
            last_wr_addr     <= mem_a;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    function automatic int nbytes(input bit fetch, input logic [1:0] size);
        if (fetch)         return 4;
        if (size == 2'd0)  return 1;
        if (size == 2'd1)  return 2;
        return 4;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr, input int n);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] a = addr + 32'(k);
            v[8*k +: 8] = model_mem[a[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] addr, input int n);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] a = addr + 32'(k);
            v[8*k +: 8] = ram[a[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] maskBytes(input logic [31:0] v, input int n);
        logic [31:0] m = 32'h0;
        for (int k = 0; k < n; k++) m[8*k +: 8] = v[8*k +: 8];
        return m;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a = addr + 32'(k);
            model_mem[a[11:0]] = wdata[8*k +: 8];
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the accepting edge.
    task automatic startTxn(input bit fetch, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_req   = 1'b1;
            ls_we    = we;
            ls_size  = size;
            ls_addr  = addr;
            ls_wdata = wdata;
        end
        tick();
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic waitDone(input bit fetch, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ((fetch && if_done) || (!fetch && ls_done)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input bit fetch, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] data, output int lat);
        int n = nbytes(fetch, size);
        startTxn(fetch, we, size, addr, wdata);
        waitDone(fetch, lat);
        if (fetch)    data = if_data;
        else if (we)  data = ramRead(addr, n);
        else          data = ls_rdata;
        if (!fetch && we) modelStore(addr, n, wdata);
    endtask

    task automatic countDone(input int cycles, output int seen);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (if_done || ls_done) seen++;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_a"},    mem_a, 32'h0);
        checkOutput({tag, "_mem_wr"},   32'(mem_wr), 32'h0);
        checkOutput({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
        checkOutput({tag, "_if_done"},  32'(if_done), 32'h0);
        checkOutput({tag, "_ls_done"},  32'(ls_done), 32'h0);
        checkOutput({tag, "_if_data"},  if_data, 32'h0);
        checkOutput({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] data, exp;
        int          lat, lat2, seen, w0, n;
        logic [31:0] data2;

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0010_0513, 5};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0200, 32'h0,         32'h0000_00FF, 2};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 5};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0302, 32'h0,         32'h0000_DEAD, 3};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 5};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0305, 32'h1234_5677, 32'h0000_0077, 1};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0305, 32'h0,         32'h0000_0077, 2};
        vecs[8]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0101, 32'h0,         32'h0000_1005, 3};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h5555_ABCD, 32'h0000_ABCD, 2};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_ABCD, 3};

        for (int i = 0; i < 4096; i++) model_mem[i] = pattern(12'(i));

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (3) tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            n  = nbytes(vecs[i].fetch, vecs[i].size);
            w0 = wr_cnt;
            applyStimulus(vecs[i].fetch, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, data, lat);
            checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_wrcount", i), 32'(wr_cnt - w0), vecs[i].we ? 32'(n) : 32'h0);
            if (vecs[i].we)
                checkOutput($sformatf("vec%0d_lastaddr", i), last_wr_addr, vecs[i].addr + 32'(n - 1));
            tick();
        end

        // Simultaneous requests: load wins, fetch follows after one idle cycle.
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
        tick();
        ls_req = 1'b0;
        lat = -1; lat2 = -1; data = 32'h0; data2 = 32'h0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ls_done) begin lat = c; data = ls_rdata; end
            if (if_done) begin lat2 = c; data2 = if_data; break; end
        end
        if_req = 1'b0;
        checkOutput("prio_ls_lat", 32'(lat), 32'd2);
        checkOutput("prio_ls_data", data, 32'h0000_00FF);
        checkOutput("prio_if_lat", 32'(lat2), 32'd8);
        checkOutput("prio_if_data", data2, 32'h0010_0513);
        tick();

        // IO store held off by a full UART buffer for three cycles.
        io_buffer_full = 1'b1;
        w0 = wr_cnt;
        startTxn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
        tick(); tick(); tick();
        checkOutput("io_stall_wrcount", 32'(wr_cnt - w0), 32'h0);
        checkOutput("io_stall_mem_wr", 32'(mem_wr), 32'h0);
        io_buffer_full = 1'b0;
        waitDone(1'b0, lat);
        modelStore(32'h0003_0000, 1, 32'h41);
        checkOutput("io_lat", 32'(lat + 3), 32'd4);
        checkOutput("io_wrcount", 32'(wr_cnt - w0), 32'd1);
        checkOutput("io_addr", last_wr_addr, 32'h0003_0000);
        checkOutput("io_data", 32'(ram[12'h000]), 32'h41);
        tick();

        // Clear while fetching byte 2 aborts without a done pulse.
        startTxn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
        tick(); tick();
        checkOutput("clr_fetch_byte2_addr", mem_a, 32'h102);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_fetch_idle_addr", mem_a, 32'h0);
        checkOutput("clr_fetch_if_done", 32'(if_done), 32'h0);
        countDone(6, seen);
        checkOutput("clr_fetch_no_done", 32'(seen), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, data, lat);
        checkOutput("after_clr_fetch_data", data, 32'h0010_0513);
        checkOutput("after_clr_fetch_lat", 32'(lat), 32'd5);
        tick();

        // Store half accepted and completed with clear held throughout.
        clear = 1'b1;
        w0 = wr_cnt;
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h400, 32'h0000_BEEF, data, lat);
        clear = 1'b0;
        checkOutput("clr_store_data", data, 32'h0000_BEEF);
        checkOutput("clr_store_lat", 32'(lat), 32'd2);
        checkOutput("clr_store_wrcount", 32'(wr_cnt - w0), 32'd2);
        tick();

        // Fetch presented together with clear is rejected.
        clear = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        tick();
        clear = 1'b0; if_req = 1'b0;
        checkOutput("clr_reject_addr", mem_a, 32'h0);
        countDone(8, seen);
        checkOutput("clr_reject_no_done", 32'(seen), 32'h0);

        // rdy low for two cycles in the middle of a word store.
        w0 = wr_cnt;
        startTxn(1'b0, 1'b1, 2'd2, 32'h500, 32'h1122_3344);
        tick();
        rdy = 1'b0;
        #1;
        checkOutput("rdy_store_mem_wr0", 32'(mem_wr), 32'h0);
        tick();
        checkOutput("rdy_store_mem_wr1", 32'(mem_wr), 32'h0);
        tick();
        rdy = 1'b1;
        waitDone(1'b0, lat);
        modelStore(32'h500, 4, 32'h1122_3344);
        checkOutput("rdy_store_lat", 32'(lat + 3), 32'd6);
        checkOutput("rdy_store_wrcount", 32'(wr_cnt - w0), 32'd4);
        checkOutput("rdy_store_data", ramRead(32'h500, 4), 32'h1122_3344);
        tick();

        // rdy low mid-fetch: the in-flight byte is re-read, data stays intact.
        startTxn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
        tick();
        rdy = 1'b0;
        tick(); tick();
        rdy = 1'b1;
        waitDone(1'b1, lat);
        checkOutput("rdy_fetch_done_seen", 32'(lat > 0), 32'd1);
        checkOutput("rdy_fetch_data", if_data, 32'h0010_0513);
        tick();

        // Reset in the middle of a load.
        startTxn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        tick(); tick();
        rst = 1'b1;
        tick();
        checkIdleOutputs("midrst");
        rst = 1'b0;
        countDone(8, seen);
        checkOutput("midrst_no_done", 32'(seen), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, data, lat);
        checkOutput("midrst_next_data", data, 32'h0010_0513);
        checkOutput("midrst_next_lat", 32'(lat), 32'd5);
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int          kind = $urandom_range(0, 2);
            bit          fetch = (kind == 0);
            bit          we = (kind == 2);
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] addr = $urandom;
            logic [31:0] wdata = $urandom;
            n   = nbytes(fetch, size);
            exp = we ? maskBytes(wdata, n) : modelRead(addr, n);
            applyStimulus(fetch, we, size, addr, wdata, data, lat);
            checkOutput($sformatf("rand%0d_data", i), data, exp);
            checkOutput($sformatf("rand%0d_lat", i), 32'(lat), we ? 32'(n) : 32'(n + 1));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
